// File: rtl/conv_pkg.sv
// Shared constants, FSM encoding and width helper for the weight scanner.
package conv_pkg;
  localparam int DEF_KSIZE = 3;
  localparam int DEF_OSIZE = 19;
  localparam int DEF_NCH   = 16;
  localparam int DEF_DW    = 8;
  localparam int DEF_AW    = 4;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCAN, S_DONE} state_t;

  // clog2 clamped to one bit so a size-1 axis still gets a legal port
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/weight_scan_if.sv
// Downstream weight stream: kernel tap for all channels plus scan coordinates.
interface weight_scan_if
  import conv_pkg::*;
#(
  parameter int KSIZE = DEF_KSIZE,
  parameter int OSIZE = DEF_OSIZE,
  parameter int NCH   = DEF_NCH,
  parameter int DW    = DEF_DW
) ();
  localparam int KW = cw(KSIZE);
  localparam int OW = cw(OSIZE);

  logic [NCH*DW-1:0] w_out;
  logic              w_valid;
  logic              w_ready;
  logic [KW-1:0]     x, y;
  logic [OW-1:0]     X, Y;

  modport master (output w_out, w_valid, x, y, X, Y, input w_ready);
  modport slave  (input w_out, w_valid, x, y, X, Y, output w_ready);
endinterface

// File: rtl/wrap_counter.sv
// Enable-gated counter 0..MAX that wraps to 0; wrap flags the terminal value.
module wrap_counter #(
  parameter int MAX = 2,
  parameter int W   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  output logic [W-1:0] q,
  output logic         wrap
);
  logic [W-1:0] q_q;

  assign wrap = (q_q == W'(MAX));
  assign q    = q_q;

  always_ff @(posedge clk) begin
    if (rst)         q_q <= '0;
    else if (enable) q_q <= wrap ? '0 : q_q + 1'b1;
  end
endmodule

// File: rtl/weight_scan.sv
// Loads a KSIZE x KSIZE kernel from NCH parallel weight memories, then streams
// every tap once per output window position under a valid/ready handshake.
module weight_scan
  import conv_pkg::*;
#(
  parameter int KSIZE = DEF_KSIZE,
  parameter int OSIZE = DEF_OSIZE,
  parameter int NCH   = DEF_NCH,
  parameter int DW    = DEF_DW,
  parameter int AW    = DEF_AW
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic              start,
  output logic [AW-1:0]     w_raddr,
  input  logic [NCH*DW-1:0] w_rdata,
  weight_scan_if.master     ws,
  output logic              busy,
  output logic              finish
);
  localparam int KW = cw(KSIZE);
  localparam int OW = cw(OSIZE);
  localparam int K2 = KSIZE * KSIZE;
  localparam logic [AW:0] K2_C = (AW+1)'(K2);

  state_t            state_q;
  logic [AW:0]       ld_cnt_q, ld_nxt;
  logic [AW-1:0]     raddr_q, ld_idx, rd_idx;
  logic              vld_q, busy_q, fin_q;
  logic [NCH*DW-1:0] bank_q [2**AW];

  logic          xfer, last;
  logic          cx_w, cy_w, cX_w, cY_w;
  logic [KW-1:0] cx, cy;
  logic [OW-1:0] cX, cY;

  assign xfer = vld_q & ws.w_ready;
  assign last = xfer & cx_w & cy_w & cX_w & cY_w;

  // x fastest, each stage enabled only when every faster stage is wrapping
  wrap_counter #(.MAX(KSIZE-1), .W(KW)) u_cx (.clk(clk), .rst(xrst), .enable(xfer),
    .q(cx), .wrap(cx_w));
  wrap_counter #(.MAX(KSIZE-1), .W(KW)) u_cy (.clk(clk), .rst(xrst), .enable(xfer & cx_w),
    .q(cy), .wrap(cy_w));
  wrap_counter #(.MAX(OSIZE-1), .W(OW)) u_cX (.clk(clk), .rst(xrst), .enable(xfer & cx_w & cy_w),
    .q(cX), .wrap(cX_w));
  wrap_counter #(.MAX(OSIZE-1), .W(OW)) u_cY (.clk(clk), .rst(xrst),
    .enable(xfer & cx_w & cy_w & cX_w), .q(cY), .wrap(cY_w));

  assign ld_nxt = ld_cnt_q + 1'b1;
  assign ld_idx = ld_cnt_q[AW-1:0] - 1'b1;
  assign rd_idx = AW'(cy) * AW'(KSIZE) + AW'(cx);

  always_ff @(posedge clk) begin
    if (xrst) begin
      state_q  <= S_IDLE;
      ld_cnt_q <= '0;
      raddr_q  <= '0;
      vld_q    <= 1'b0;
      busy_q   <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          fin_q <= 1'b0;
          if (start) begin
            state_q  <= S_LOAD;
            ld_cnt_q <= '0;
            raddr_q  <= '0;
            busy_q   <= 1'b1;
          end
        end
        S_LOAD: begin
          // one extra cycle after the last address lets its read data land
          ld_cnt_q <= ld_nxt;
          raddr_q  <= (ld_nxt < K2_C) ? ld_nxt[AW-1:0] : '0;
          if (ld_cnt_q == K2_C) begin
            state_q <= S_SCAN;
            vld_q   <= 1'b1;
            raddr_q <= '0;
          end
        end
        S_SCAN: begin
          if (last) begin
            state_q <= S_DONE;
            vld_q   <= 1'b0;
            fin_q   <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          fin_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // read data for address a arrives while ld_cnt_q == a+1
  always_ff @(posedge clk) begin
    if (xrst) begin
      for (int i = 0; i < 2**AW; i++) bank_q[i] <= '0;
    end else if (state_q == S_LOAD && ld_cnt_q != '0) begin
      bank_q[ld_idx] <= w_rdata;
    end
  end

  assign ws.w_out   = bank_q[rd_idx];
  assign ws.w_valid = vld_q;
  assign ws.x       = cx;
  assign ws.y       = cy;
  assign ws.X       = cX;
  assign ws.Y       = cY;
  assign w_raddr    = raddr_q;
  assign busy       = busy_q;
  assign finish     = fin_q;
endmodule

// File: doc/weight_scan.md
WEIGHT_SCAN -- requirements
Module: weight_scan

Interface
REQ-001 SHALL have parameter KSIZE, default 3, kernel edge length (x, y range 0..KSIZE-1).
REQ-002 SHALL have parameter OSIZE, default 19, window positions per axis (X, Y range 0..OSIZE-1).
REQ-003 SHALL have parameter NCH, default 16, number of weight channels read in parallel.
REQ-004 SHALL have parameter DW, default 8, signed weight width.
REQ-005 SHALL have parameter AW, default 4, weight-memory address width; requires 2**AW >= KSIZE*KSIZE.
REQ-006 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-007 SHALL have port xrst, input, 1, synchronous active-high reset (name retained; polarity is high).
REQ-008 SHALL have port start, input, 1, one-cycle request to load and scan.
REQ-009 SHALL have port w_raddr, output, AW, address shared by all NCH weight memories.
REQ-010 SHALL have port w_rdata, input, NCH*DW, packed signed read data, channel c at bits [c*DW +: DW], valid 1 cycle after w_raddr.
REQ-011 SHALL have port w_out, output, NCH*DW, current kernel tap for all channels, same packing.
REQ-012 SHALL have port w_valid, output, 1, w_out and coordinates valid.
REQ-013 SHALL have port w_ready, input, 1, downstream accepts; a beat transfers when w_valid and w_ready are both 1.
REQ-014 SHALL have ports x, y (clog2(KSIZE) bits) and X, Y (clog2(OSIZE) bits), outputs, scan coordinates of current beat.
REQ-015 SHALL have port busy, output, 1, high outside IDLE.
REQ-016 SHALL have port finish, output, 1, one-cycle pulse after last beat.

Function
REQ-017 SHALL implement states IDLE, LOAD, SCAN, DONE.
REQ-018 IDLE: start=1 SHALL move to LOAD next cycle; start in any other state SHALL be ignored.
REQ-019 LOAD: w_raddr SHALL step 0..KSIZE*KSIZE-1, one address per cycle; data for address a SHALL be captured into kernel register bank entry a one cycle later.
REQ-020 LOAD SHALL last KSIZE*KSIZE+1 cycles, then enter SCAN; w_raddr SHALL be 0 outside LOAD.
REQ-021 SCAN: w_valid SHALL be 1; w_out SHALL be bank entry y*KSIZE+x.
REQ-022 Counters SHALL advance only on transfer; order x fastest, then y, then X, then Y, each wrapping to 0 at its max and carrying to the next.
REQ-023 With w_ready=0, w_out, x, y, X, Y SHALL hold unchanged (no drop, no repeat).
REQ-024 Transfer at x=y=KSIZE-1, X=Y=OSIZE-1 SHALL move to DONE; total transfers = KSIZE*KSIZE*OSIZE*OSIZE (3249 default).
REQ-025 DONE SHALL last one cycle with finish=1, w_valid=0, then return to IDLE.
REQ-026 Kernel bank SHALL retain contents in IDLE; it is overwritten only in LOAD.
REQ-027 Weights SHALL pass through unmodified (no arithmetic, sign preserved).

Reset
REQ-028 xrst=1 at a clock edge SHALL force IDLE, x=y=X=Y=0, w_raddr=0, w_valid=0, busy=0, finish=0, bank entries 0.
REQ-029 Reset mid-LOAD or mid-SCAN SHALL abort with no finish pulse; start in the reset cycle SHALL be ignored.

Structure
REQ-030 State encoding and default parameter constants SHALL live in shared package conv_pkg.
REQ-031 One sub-module, wrap_counter (parameter MAX, inputs enable, outputs q, wrap), SHALL be instantiated four times for x, y, X, Y.

Verification
REQ-032 Memory returns value 8'(16*c+a) for channel c, address a; start -> w_raddr 0..8, first beat w_out ch0=0, ch15=0xF0 with x=y=X=Y=0.
REQ-033 w_ready=1 constant -> exactly 3249 beats, finish one cycle after the last, busy falls with finish.
REQ-034 w_ready toggled randomly at 50% -> beat sequence identical to REQ-033 run, coordinates held during stalls.
REQ-035 Beat 4 (x=1,y=1) -> w_out equals entry 4; beat 9 -> x=y=0, X=1.
REQ-036 xrst pulsed at beat 1000 -> next cycle IDLE, w_valid=0, no finish; new start rescans from 0.
REQ-037 start pulsed during SCAN -> ignored, beat count still 3249; negative weight 0x80 emerges as 0x80.
